// File: rtl/game_ctrl_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_ctrl_fsm_if : control/status bundle between match FSM and ball side |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface game_ctrl_fsm_if;
   logic       tick_1ms;
   logic       btn_start;
   logic       btn_pause;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] game_state;
   logic [1:0] winner;
   logic       match_clr_n;
   logic       serve_active;

   modport master (
      input  tick_1ms, btn_start, btn_pause, p1_score, p2_score,
      output game_state, winner, match_clr_n, serve_active
   );

   modport slave (
      output tick_1ms, btn_start, btn_pause, p1_score, p2_score,
      input  game_state, winner, match_clr_n, serve_active
   );
endinterface
`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_ctrl_fsm : debounced start/pause, IDLE/SERVE/PLAY/PAUSE/OVER control |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module game_ctrl_fsm #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_MS    = 1000,
   parameter int DEBOUNCE_MS = 10,
   parameter int CNT_W       = 10
) (
   input  logic            clk,
   input  logic            reset,
   game_ctrl_fsm_if.master bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SERVE = 3'd1;
   localparam logic [2:0] PLAY  = 3'd2;
   localparam logic [2:0] PAUSE = 3'd3;
   localparam logic [2:0] OVER  = 3'd4;

   localparam logic [CNT_W-1:0] SERVE_MAX  = CNT_W'(SERVE_MS);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_MS - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
   localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

   logic [1:0] btn_raw;
   logic [1:0] btn_evt;
   logic       start_evt;
   logic       pause_evt;

   assign btn_raw   = {bus.btn_pause, bus.btn_start};
   assign start_evt = btn_evt[0];
   assign pause_evt = btn_evt[1];

   generate
      for (genvar i = 0; i < 2; i++) begin : g_btn
         logic             sync_a;
         logic             sync_b;
         logic             deb;
         logic             deb_q;
         logic [CNT_W-1:0] cnt;

         // cnt measures how long the synced level has disagreed with the accepted level
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_a <= 1'b0;
               sync_b <= 1'b0;
               deb    <= 1'b0;
               deb_q  <= 1'b0;
               cnt    <= '0;
            end else begin
               sync_a <= btn_raw[i];
               sync_b <= sync_a;
               deb_q  <= deb;
               if (sync_b == deb) begin
                  cnt <= '0;
               end else if (bus.tick_1ms) begin
                  if (cnt >= DEB_LAST) begin
                     deb <= sync_b;
                     cnt <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         end

         assign btn_evt[i] = deb & ~deb_q;
      end
   endgenerate

   logic [7:0]       score_hist;
   logic             point_evt;
   logic             p1_win;
   logic             p2_win;

   assign point_evt = ({bus.p1_score, bus.p2_score} != score_hist);
   assign p1_win    = (bus.p1_score >= WIN);
   assign p2_win    = (bus.p2_score >= WIN);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [1:0]       winner_q;
   logic [1:0]       winner_nxt;
   logic             clr_start;
   logic [CNT_W-1:0] serve_cnt;
   logic [1:0]       game_state_q;
   logic             serve_active_q;
   logic             match_clr_n_q;

   always_comb begin
      state_nxt  = state;
      winner_nxt = winner_q;
      clr_start  = 1'b0;
      case (state)
         IDLE: begin
            if (start_evt) begin
               state_nxt = SERVE;
               clr_start = 1'b1;
            end
         end
         SERVE: begin
            if (bus.tick_1ms && (serve_cnt >= SERVE_LAST)) begin
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (point_evt) begin
               if (p1_win || p2_win) begin
                  state_nxt  = OVER;
                  winner_nxt = {p2_win, p1_win};
               end else begin
                  state_nxt = SERVE;
               end
            end else if (pause_evt) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (pause_evt || start_evt) begin
               state_nxt = PLAY;
            end
         end
         OVER: begin
            if (start_evt) begin
               state_nxt  = SERVE;
               clr_start  = 1'b1;
               winner_nxt = 2'b00;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         winner_q       <= 2'b00;
         serve_cnt      <= '0;
         score_hist     <= 8'h00;
         game_state_q   <= 2'b00;
         serve_active_q <= 1'b0;
         match_clr_n_q  <= 1'b1;
      end else begin
         state          <= state_nxt;
         winner_q       <= winner_nxt;
         score_hist     <= {bus.p1_score, bus.p2_score};
         serve_active_q <= (state_nxt == SERVE);

         case (state_nxt)
            PLAY:    game_state_q <= 2'b01;
            PAUSE:   game_state_q <= 2'b10;
            OVER:    game_state_q <= 2'b11;
            default: game_state_q <= 2'b00;
         endcase

         if ((state_nxt == SERVE) && (state != SERVE)) begin
            serve_cnt <= '0;
         end else if ((state == SERVE) && bus.tick_1ms && (serve_cnt < SERVE_MAX)) begin
            serve_cnt <= serve_cnt + 1'b1;
         end

         // released on a tick edge so the ball's ms logic samples exactly one low
         if (clr_start) begin
            match_clr_n_q <= 1'b0;
         end else if (!match_clr_n_q && bus.tick_1ms) begin
            match_clr_n_q <= 1'b1;
         end
      end
   end

   assign bus.game_state   = game_state_q;
   assign bus.winner       = winner_q;
   assign bus.match_clr_n  = match_clr_n_q;
   assign bus.serve_active = serve_active_q;
endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_game_ctrl_fsm : directed bench for game_ctrl_fsm, tick every 4 clk     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_game_ctrl_fsm;
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] ph    = 2'd0;
   int         total = 0;
   int         bad   = 0;

   game_ctrl_fsm_if bus ();

   game_ctrl_fsm #(
      .WIN_SCORE   (3),
      .SERVE_MS    (3),
      .DEBOUNCE_MS (2),
      .CNT_W       (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // tick is high during the cycle whose closing posedge sees ph==3
   always @(posedge clk) ph <= ph + 2'd1;
   assign bus.tick_1ms = (ph == 2'd3);

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // land on the negedge just after a tick edge
   task automatic align();
      while (ph != 2'd0) step(1);
   endtask

   task automatic wait_gs(input string tag, input int exp, input int budget);
      int n = 0;
      while (int'(bus.game_state) != exp && n < budget) begin
         step(1);
         n++;
      end
      chk(tag, int'(bus.game_state), exp);
   endtask

   initial begin
      bus.btn_start = 1'b0;
      bus.btn_pause = 1'b0;
      bus.p1_score  = 4'd0;
      bus.p2_score  = 4'd0;
      #1 reset = 1'b0;
      step(3);
      chk("rst_gs",    int'(bus.game_state),   0);
      chk("rst_win",   int'(bus.winner),       0);
      chk("rst_clr",   int'(bus.match_clr_n),  1);
      chk("rst_serve", int'(bus.serve_active), 0);
      reset = 1'b1;
      step(4);

      // short glitch: synced window spans only one tick
      align();
      bus.btn_start = 1'b1;
      step(5);
      bus.btn_start = 1'b0;
      step(16);
      chk("glitch_gs",    int'(bus.game_state),   0);
      chk("glitch_serve", int'(bus.serve_active), 0);
      chk("glitch_clr",   int'(bus.match_clr_n),  1);

      // held start: accepted on 2nd tick, SERVE one clk later
      align();
      bus.btn_start = 1'b1;
      step(8);
      chk("start_early", int'(bus.serve_active), 0);
      step(1);
      chk("start_serve", int'(bus.serve_active), 1);
      chk("start_clr0",  int'(bus.match_clr_n),  0);
      chk("start_gs",    int'(bus.game_state),   0);
      step(2);
      chk("clr_hold",    int'(bus.match_clr_n),  0);
      step(1);
      chk("clr_release", int'(bus.match_clr_n),  1);
      step(7);
      chk("serve_wait",  int'(bus.game_state),   0);
      step(1);
      chk("serve_play",  int'(bus.game_state),   1);
      chk("play_nosrv",  int'(bus.serve_active), 0);

      // point without win returns to SERVE
      align();
      bus.btn_start = 1'b0;
      bus.p1_score  = 4'd1;
      step(1);
      chk("pt_gs",     int'(bus.game_state),   0);
      chk("pt_serve",  int'(bus.serve_active), 1);
      chk("pt_win",    int'(bus.winner),       0);
      step(7);
      chk("pt_wait",   int'(bus.game_state),   0);
      chk("pt_noclr",  int'(bus.match_clr_n),  1);
      step(4);
      chk("pt_play",   int'(bus.game_state),   1);

      // pause, score change frozen, start resumes
      align();
      bus.btn_pause = 1'b1;
      step(8);
      chk("pause_early", int'(bus.game_state), 1);
      step(1);
      chk("pause_gs",    int'(bus.game_state), 2);
      bus.btn_pause = 1'b0;
      bus.p2_score  = 4'd1;
      step(3);
      chk("pause_frozen", int'(bus.game_state), 2);
      step(12);
      align();
      bus.btn_start = 1'b1;
      step(8);
      chk("resume_early", int'(bus.game_state), 2);
      step(1);
      chk("resume_gs",    int'(bus.game_state), 1);
      bus.btn_start = 1'b0;
      step(14);
      chk("resume_hold",  int'(bus.game_state), 1);

      // winning point arrives with a pause press: point wins
      bus.p1_score = 4'd2;
      step(1);
      chk("p1_two_serve", int'(bus.game_state), 0);
      wait_gs("p1_two_play", 1, 20);
      align();
      bus.btn_pause = 1'b1;
      step(8);
      bus.p1_score = 4'd3;
      step(1);
      chk("over_gs",  int'(bus.game_state), 3);
      chk("over_win", int'(bus.winner),     1);
      bus.btn_pause = 1'b0;
      step(14);
      chk("over_pause_ign", int'(bus.game_state), 3);
      align();
      bus.btn_start = 1'b1;
      step(9);
      chk("rematch_gs",    int'(bus.game_state),   0);
      chk("rematch_win",   int'(bus.winner),       0);
      chk("rematch_clr0",  int'(bus.match_clr_n),  0);
      chk("rematch_serve", int'(bus.serve_active), 1);
      step(3);
      chk("rematch_clr1",  int'(bus.match_clr_n),  1);
      bus.btn_start = 1'b0;

      // simultaneous win, then async reset in SERVE
      bus.p1_score = 4'd2;
      bus.p2_score = 4'd2;
      wait_gs("tie_play", 1, 20);
      step(12);
      bus.p1_score = 4'd3;
      bus.p2_score = 4'd3;
      step(1);
      chk("tie_gs",  int'(bus.game_state), 3);
      chk("tie_win", int'(bus.winner),     3);
      align();
      bus.btn_start = 1'b1;
      step(9);
      chk("tie_restart",   int'(bus.serve_active), 1);
      chk("tie_win_clr",   int'(bus.winner),       0);
      step(1);
      chk("pre_rst_clr",   int'(bus.match_clr_n),  0);
      #2 reset = 1'b0;
      #1;
      chk("arst_serve", int'(bus.serve_active), 0);
      chk("arst_clr",   int'(bus.match_clr_n),  1);
      chk("arst_gs",    int'(bus.game_state),   0);
      chk("arst_win",   int'(bus.winner),       0);
      bus.btn_start = 1'b0;
      step(2);
      reset = 1'b1;
      step(16);
      chk("post_rst_gs",    int'(bus.game_state),   0);
      chk("post_rst_serve", int'(bus.serve_active), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
